// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: one shared decoder, per-digit slots with
// optional blanking gap, and a double-buffered load port that commits at frame boundaries.
module seg7_scan_ctrl #(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned PRESCALE  = 4,
  parameter int unsigned BLANK_GAP = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      load_valid,
  input  logic [4*DIGITS-1:0]       load_data,
  output logic                      load_ready,
  input  logic                      lz_blank,
  output logic [6:0]                seg,
  output logic [DIGITS-1:0]         an,
  output logic [$clog2(DIGITS)-1:0] digit_idx,
  output logic                      frame_done
);

  localparam int unsigned IDX_W   = $clog2(DIGITS);
  localparam int unsigned DW      = 4 * DIGITS;
  localparam int unsigned CNT_MAX = (PRESCALE > BLANK_GAP) ? PRESCALE : BLANK_GAP;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]      active_q, active_d;
  logic [DW-1:0]      pending_q, pending_d;
  logic               pend_full_q, pend_full_d;
  logic [6:0]         seg_q, seg_d;
  logic [DIGITS-1:0]  an_q, an_d;
  logic               fd_q, fd_d;
  logic               boundary;
  logic               last_digit;
  logic [3:0]         nib;
  logic [DIGITS-1:0]  blank_mask;

  // Hex nibble to {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Leading-zero digits from the top down to the first nonzero one; digit 0 always shown
  function automatic logic [DIGITS-1:0] lz_mask(input logic [DW-1:0] v);
    logic [DIGITS-1:0] m;
    logic              lead;
    m    = '0;
    lead = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      if (lead && (v[4*i +: 4] == 4'h0)) begin
        m[i] = 1'b1;
      end else begin
        lead = 1'b0;
      end
    end
    return m;
  endfunction

  assign last_digit = (idx_q == IDX_W'(DIGITS - 1));

  // Next-state, buffer and registered-output logic
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    active_d    = active_q;
    pending_d   = pending_q;
    pend_full_d = pend_full_q;
    boundary    = 1'b0;
    seg_d       = '0;
    an_d        = '0;
    fd_d        = 1'b0;
    nib         = '0;
    blank_mask  = '0;

    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = SHOW;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      SHOW: begin
        if (cnt_q == CNT_W'(PRESCALE - 1)) begin
          cnt_d = '0;
          if (BLANK_GAP == 0) begin
            idx_d    = last_digit ? '0 : idx_q + IDX_W'(1);
            boundary = last_digit;
          end else begin
            state_d = GAP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(BLANK_GAP - 1)) begin
          cnt_d    = '0;
          state_d  = SHOW;
          idx_d    = last_digit ? '0 : idx_q + IDX_W'(1);
          boundary = last_digit;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase

    // Disable wins over any slot progress; no commit or frame pulse
    if (!en) begin
      state_d  = IDLE;
      idx_d    = '0;
      cnt_d    = '0;
      boundary = 1'b0;
    end

    // Commit and accept are mutually exclusive: one needs pending full, the other empty
    if (boundary && pend_full_q) begin
      active_d    = pending_q;
      pend_full_d = 1'b0;
    end
    if (load_valid && !pend_full_q) begin
      pending_d   = load_data;
      pend_full_d = 1'b1;
    end

    fd_d = boundary;

    // Outputs follow the next state so a new frame already shows committed data
    if (state_d == SHOW) begin
      nib        = active_d[4*int'(idx_d) +: 4];
      blank_mask = lz_blank ? lz_mask(active_d) : '0;
      an_d       = DIGITS'(1) << idx_d;
      seg_d      = blank_mask[idx_d] ? 7'h00 : hex7(nib);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      active_q    <= '0;
      pending_q   <= '0;
      pend_full_q <= 1'b0;
      seg_q       <= '0;
      an_q        <= '0;
      fd_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      active_q    <= active_d;
      pending_q   <= pending_d;
      pend_full_q <= pend_full_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      fd_q        <= fd_d;
    end
  end

  assign load_ready = ~pend_full_q;
  assign seg        = seg_q;
  assign an         = an_q;
  assign digit_idx  = idx_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: per-cycle expected an/seg/frame_done/digit_idx
// are queued from the display contents when stimulus is applied and popped each cycle.
module tb_seg7_scan_ctrl;

  localparam int unsigned DIGITS    = 4;
  localparam int unsigned PRESCALE  = 4;
  localparam int unsigned BLANK_GAP = 1;

  logic        clk;
  logic        rst;
  logic        en;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;
  logic        lz_blank;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [1:0]  digit_idx;
  logic        frame_done;

  seg7_scan_ctrl #(
    .DIGITS   (DIGITS),
    .PRESCALE (PRESCALE),
    .BLANK_GAP(BLANK_GAP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_ready(load_ready),
    .lz_blank  (lz_blank),
    .seg       (seg),
    .an        (an),
    .digit_idx (digit_idx),
    .frame_done(frame_done)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       fd;
    logic [1:0] idx;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [6:0] hexseg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F; 4'h1: s = 7'h06; 4'h2: s = 7'h5B; 4'h3: s = 7'h4F;
      4'h4: s = 7'h66; 4'h5: s = 7'h6D; 4'h6: s = 7'h7D; 4'h7: s = 7'h07;
      4'h8: s = 7'h7F; 4'h9: s = 7'h6F; 4'hA: s = 7'h77; 4'hB: s = 7'h7C;
      4'hC: s = 7'h39; 4'hD: s = 7'h5E; 4'hE: s = 7'h79; default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Queue the first ncyc cycles of a frame displaying data
  task automatic push_frame(input logic [15:0] data, input logic lz, input logic fd, input int ncyc);
    int         n;
    logic       lead;
    logic [3:0] blank;
    exp_t       e;
    n     = 0;
    lead  = 1'b1;
    blank = '0;
    for (int d = 3; d >= 1; d--) begin
      if (lz && lead && data[4*d +: 4] == 4'h0) blank[d] = 1'b1;
      else lead = 1'b0;
    end
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < int'(PRESCALE); c++) begin
        e.an  = 4'(1 << d);
        e.seg = blank[d] ? 7'h00 : hexseg(data[4*d +: 4]);
        e.fd  = fd && (d == 0) && (c == 0);
        e.idx = 2'(d);
        if (n < ncyc) sb.push_back(e);
        n++;
      end
      for (int g = 0; g < int'(BLANK_GAP); g++) begin
        e.an  = '0;
        e.seg = '0;
        e.fd  = 1'b0;
        e.idx = 2'(d);
        if (n < ncyc) sb.push_back(e);
        n++;
      end
    end
  endtask

  task automatic push_idle(input int ncyc);
    exp_t e;
    e = '0;
    for (int i = 0; i < ncyc; i++) sb.push_back(e);
  endtask

  // One clock: sample at the falling edge and compare against the queue head
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check("an", 32'(an), 32'(e.an));
      check("seg", 32'(seg), 32'(e.seg));
      check("frame_done", 32'(frame_done), 32'(e.fd));
      check("digit_idx", 32'(digit_idx), 32'(e.idx));
    end
  endtask

  initial begin
    rst        = 1'b0;
    en         = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    lz_blank   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_an", 32'(an), 32'd0);
    check("rst_seg", 32'(seg), 32'd0);
    check("rst_idx", 32'(digit_idx), 32'd0);
    check("rst_fd", 32'(frame_done), 32'd0);
    check("rst_ready", 32'(load_ready), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("idle_an", 32'(an), 32'd0);

    // Scan of all-zero active value, two frames
    push_frame(16'h0000, 1'b0, 1'b0, 20);
    push_frame(16'h0000, 1'b0, 1'b1, 20);
    en = 1'b1;
    repeat (40) cycle();

    // Mid-frame load, committed at the boundary
    push_frame(16'h0000, 1'b0, 1'b1, 20);
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (i == 5) begin load_valid = 1'b1; load_data = 16'h1A2F; end
      if (i == 6) begin check("ready_drop", 32'(load_ready), 32'd0); load_valid = 1'b0; end
    end

    // Back-to-back loads held valid: 0000 accepted, 1234 waits past the boundary
    push_frame(16'h1A2F, 1'b0, 1'b1, 20);
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (i == 0) check("ready_after_commit", 32'(load_ready), 32'd1);
      if (i == 2) begin load_valid = 1'b1; load_data = 16'h0000; end
      if (i == 3) begin check("ready_hold", 32'(load_ready), 32'd0); load_data = 16'h1234; end
    end
    push_frame(16'h0000, 1'b0, 1'b1, 20);
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (i == 0) check("ready_boundary_no_accept", 32'(load_ready), 32'd1);
      if (i == 1) begin check("ready_second_accept", 32'(load_ready), 32'd0); load_valid = 1'b0; end
    end

    // Leading-zero blanking
    push_frame(16'h1234, 1'b0, 1'b1, 20);
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (i == 0) lz_blank = 1'b1;
      if (i == 2) begin load_valid = 1'b1; load_data = 16'h0050; end
      if (i == 3) load_valid = 1'b0;
    end
    push_frame(16'h0050, 1'b1, 1'b1, 20);
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (i == 2) begin load_valid = 1'b1; load_data = 16'h0000; end
      if (i == 3) load_valid = 1'b0;
    end
    push_frame(16'h0000, 1'b1, 1'b1, 20);
    repeat (20) cycle();

    // Enable dropped during digit 2 with a load pending
    push_frame(16'h0000, 1'b1, 1'b1, 12);
    push_idle(4);
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (i == 1) begin load_valid = 1'b1; load_data = 16'hC0DE; end
      if (i == 2) load_valid = 1'b0;
      if (i == 11) en = 1'b0;
    end
    repeat (4) begin
      cycle();
      check("ready_idle_pending", 32'(load_ready), 32'd0);
    end
    lz_blank = 1'b0;
    en       = 1'b1;
    push_frame(16'h0000, 1'b0, 1'b0, 20);
    push_frame(16'hC0DE, 1'b0, 1'b1, 20);
    repeat (40) cycle();

    // Asynchronous reset mid-frame with pending full
    push_frame(16'hC0DE, 1'b0, 1'b1, 8);
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (i == 2) begin load_valid = 1'b1; load_data = 16'h5555; end
      if (i == 3) begin check("ready_pre_rst", 32'(load_ready), 32'd0); load_valid = 1'b0; end
    end
    #2 rst = 1'b0;
    #1;
    check("arst_an", 32'(an), 32'd0);
    check("arst_seg", 32'(seg), 32'd0);
    check("arst_idx", 32'(digit_idx), 32'd0);
    check("arst_fd", 32'(frame_done), 32'd0);
    check("arst_ready", 32'(load_ready), 32'd1);
    sb.delete();
    @(negedge clk);
    push_frame(16'h0000, 1'b0, 1'b0, 20);
    push_frame(16'h0000, 1'b0, 1'b1, 20);
    rst = 1'b1;
    repeat (40) cycle();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexing controller that shares one 7-segment decoder and one segment bus among DIGITS hex digits. It sequences digit slots with a prescaler and inserts a blanking gap between digits against ghosting. New display values are double-buffered through a valid/ready load port and committed only at frame boundaries. It sits between the counter datapath (which supplies packed nibbles) and the board's segment/anode pins.

## Interface
- DIGITS, 4: number of multiplexed digits (2..8).
- PRESCALE, 4: clock cycles each digit is lit (≥1).
- BLANK_GAP, 1: all-off cycles after each digit (≥0; 0 = no gap state).
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  scan enable; 0 forces IDLE.
- load_valid  input  1  load_data valid.
- load_data  input  4*DIGITS  packed nibbles; digit i = load_data[4i+3:4i], digit 0 least significant.
- load_ready  output  1  pending buffer empty; load accepted when load_valid && load_ready.
- lz_blank  input  1  blank leading zeros.
- seg  output  7  {g,f,e,d,c,b,a}, active-high, registered.
- an  output  DIGITS  one-hot digit select, active-high, registered.
- digit_idx  output  clog2(DIGITS)  digit currently in slot.
- frame_done  output  1  one-cycle pulse at each frame boundary.

## Operation
- Storage: active register (displayed) and pending register + pending_full flag; load_ready = ~pending_full.
- States: IDLE, SHOW, GAP.
- IDLE: seg=0, an=0, digit_idx=0, prescale counter=0. en=1 → SHOW, digit 0.
- SHOW: an = one-hot(digit_idx), seg = decode(active nibble digit_idx). After PRESCALE cycles → GAP (or directly to next digit's SHOW if BLANK_GAP=0).
- GAP: seg=0, an=0 for BLANK_GAP cycles; then digit_idx+1 → SHOW.
- Wrap: leaving the last digit's slot (GAP, or SHOW if BLANK_GAP=0) → digit_idx=0, frame boundary.
- Frame boundary edge: frame_done=1 for one cycle; if pending_full, active←pending, pending_full←0.
- Load accepted on an edge where load_valid && load_ready: pending←load_data, pending_full←1. Loads while ready=0 are not accepted; pending holds until the next boundary.
- Load and boundary on the same edge with pending empty: data goes to pending, not active; committed at the next boundary.
- Boundary with pending full and load_valid on the same edge: transfer happens; the load is not accepted (ready was 0 that cycle); it is accepted on the next edge.
- Decode (hex): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- lz_blank=1: digits from DIGITS-1 downward whose nibble is 0, up to the first nonzero digit, output seg=0 while an is still driven. Digit 0 is never blanked. The blank mask derives from the active register.
- en=0 at any point: next edge → IDLE; counters and digit_idx clear; no transfer; no frame_done. Loading still works in IDLE.

## Timing
- Reset (rst=0, async): state IDLE, seg=0, an=0, digit_idx=0, frame_done=0, active=0, pending_full=0 (load_ready=1).
- en sampled 1 at edge k in IDLE: after edge k, an=one-hot(0) and seg=decoded digit 0. Outputs change on the same edge as state.
- Frame length = DIGITS*(PRESCALE+BLANK_GAP) cycles. First boundary occurs one frame after SHOW entry.
- frame_done is high in the first cycle of digit 0 of the new frame. That cycle already shows the newly committed data.
- Load-to-display latency: from acceptance to the next boundary; at most one frame.
- rst asserted mid-frame: immediate return to reset values, pending data discarded.

## Test plan
- Reset, then en=1 with active=0 (DIGITS=4, PRESCALE=4, BLANK_GAP=1) -> an sequence 0001×4, 0000×1, 0010×4, 0000, 0100×4, 0000, 1000×4, 0000; seg=3F in every SHOW cycle; frame_done pulse every 20 cycles.
- Load 16'h1A2F mid-frame -> load_ready drops next cycle; display unchanged until the boundary; next frame seg = 71, 5B, 77, 06 for digits 0..3; load_ready=1 after the boundary.
- Hold load_valid with 16'h0000 then 16'h1234 back-to-back -> second value not accepted until after the boundary; frames show 0000 and then 1234 in order, with nothing lost.
- lz_blank=1, active=16'h0050 -> digits 3 and 2 seg=00 with an asserted; digit 1 seg=6D; digit 0 seg=3F. active=16'h0000 -> only digit 0 lit (3F).
- en dropped during digit 2 -> next cycle an=0, seg=0, digit_idx=0, no frame_done, pending not committed; re-enable -> restarts at digit 0.
- rst pulsed low mid-frame with pending full -> outputs at reset values asynchronously; load_ready=1; display of active=0 after re-enable.
